// File: rtl/uart_packet_rx.sv
// Packet assembler behind a UART word receiver: header decode, payload capture, hold-until-consumed.
// Optional trailing XOR checksum on write packets is enabled by defining UART_PACKET_CHECKSUM_EN.
module uart_packet_rx #(
  parameter int BYTE_COUNT     = 4,
  parameter int DATA_BITS      = 12,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MSB_FIRST      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_BITS-1:0]    rx_data,
  input  logic                    rx_valid,
  output logic [BYTE_COUNT*8-1:0] data_out,
  output logic [8:0]              target_addr,
  output logic                    target_mem_type,
  output logic                    rw_flag,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic                    err_timeout,
  output logic                    err_overrun,
  output logic                    err_checksum
);

  localparam int CNT_W = $clog2(BYTE_COUNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_PACKET_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, DATA, CHECK, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, HOLD} state_t;
`endif

  state_t                  state, state_n;
  logic [CNT_W-1:0]        byte_cnt, byte_cnt_n;
  logic [TMO_W-1:0]        idle_cnt, idle_cnt_n;
  logic [BYTE_COUNT*8-1:0] data_n;
  logic [8:0]              addr_n;
  logic                    mem_type_n;
  logic                    rw_n;
  logic                    tmo_n;
  logic                    ovr_n;
  logic                    timed_out;

  // Bits above the 12-bit word format carry nothing for this block.
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_data;

`ifdef UART_PACKET_CHECKSUM_EN
  logic [7:0] csum_acc, csum_acc_n;
  logic       csum_err_n;
`endif

  assign timed_out = !rx_valid && (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    idle_cnt_n = '0;
    data_n     = data_out;
    addr_n     = target_addr;
    mem_type_n = target_mem_type;
    rw_n       = rw_flag;
    tmo_n      = 1'b0;
    ovr_n      = 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
    csum_acc_n = csum_acc;
    csum_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_valid && rx_data[11:10] == 2'b11) begin
          rw_n       = 1'b1;
          mem_type_n = rx_data[9];
          addr_n     = rx_data[8:0];
          byte_cnt_n = '0;
`ifdef UART_PACKET_CHECKSUM_EN
          csum_acc_n = '0;
`endif
          state_n    = DATA;
        end else if (rx_valid && rx_data[11:10] == 2'b01) begin
          rw_n       = 1'b0;
          mem_type_n = rx_data[9];
          addr_n     = rx_data[8:0];
          state_n    = HOLD;
        end
      end
      DATA: begin
        if (rx_valid) begin
          for (int unsigned i = 0; i < BYTE_COUNT; i++) begin
            if (byte_cnt == CNT_W'(i)) begin
              if (MSB_FIRST != 0)
                data_n[(BYTE_COUNT-1-i)*8 +: 8] = rx_data[7:0];
              else
                data_n[i*8 +: 8] = rx_data[7:0];
            end
          end
          byte_cnt_n = byte_cnt + 1'b1;
`ifdef UART_PACKET_CHECKSUM_EN
          csum_acc_n = csum_acc ^ rx_data[7:0];
          if (byte_cnt == CNT_W'(BYTE_COUNT - 1)) state_n = CHECK;
`else
          if (byte_cnt == CNT_W'(BYTE_COUNT - 1)) state_n = HOLD;
`endif
        end else if (timed_out) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else if (idle_cnt != '1) begin
          idle_cnt_n = idle_cnt + 1'b1;
        end else begin
          idle_cnt_n = idle_cnt;
        end
      end
`ifdef UART_PACKET_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data[7:0] == csum_acc) begin
            state_n = HOLD;
          end else begin
            csum_err_n = 1'b1;
            state_n    = IDLE;
          end
        end else if (timed_out) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else if (idle_cnt != '1) begin
          idle_cnt_n = idle_cnt + 1'b1;
        end else begin
          idle_cnt_n = idle_cnt;
        end
      end
`endif
      HOLD: begin
        // Words arriving while a packet is pending are dropped even on the hand-off cycle.
        if (rx_valid) ovr_n = 1'b1;
        if (pkt_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      idle_cnt        <= '0;
      data_out        <= '0;
      target_addr     <= '0;
      target_mem_type <= 1'b0;
      rw_flag         <= 1'b0;
      pkt_valid       <= 1'b0;
      err_timeout     <= 1'b0;
      err_overrun     <= 1'b0;
    end else begin
      state           <= state_n;
      byte_cnt        <= byte_cnt_n;
      idle_cnt        <= idle_cnt_n;
      data_out        <= data_n;
      target_addr     <= addr_n;
      target_mem_type <= mem_type_n;
      rw_flag         <= rw_n;
      pkt_valid       <= (state_n == HOLD);
      err_timeout     <= tmo_n;
      err_overrun     <= ovr_n;
    end
  end

`ifdef UART_PACKET_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_acc     <= '0;
      err_checksum <= 1'b0;
    end else begin
      csum_acc     <= csum_acc_n;
      err_checksum <= csum_err_n;
    end
  end
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: doc/uart_packet_rx.md
UART_PACKET_RX -- requirements
Module: uart_packet_rx

Interface
REQ-001 SHALL have parameter BYTE_COUNT, default 4, number of payload bytes per write packet (1..16).
REQ-002 SHALL have parameter DATA_BITS, default 12, width of each received UART word (>=12).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum clk cycles allowed between accepted words inside a packet (>=2).
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = first payload byte lands in data_out top byte; 0 = first byte lands in bits [7:0].
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port rx_data, input, DATA_BITS, word from the bit-level UART receiver.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port data_out, output, BYTE_COUNT*8, assembled payload.
REQ-010 SHALL have port target_addr, output, 9, memory address from header.
REQ-011 SHALL have port target_mem_type, output, 1, memory select from header.
REQ-012 SHALL have port rw_flag, output, 1, 1 = write packet, 0 = read packet.
REQ-013 SHALL have port pkt_valid, output, 1, packet available; held until consumed.
REQ-014 SHALL have port pkt_ready, input, 1, consumer accepts packet when high with pkt_valid.
REQ-015 SHALL have ports err_timeout, err_overrun, err_checksum, output, 1 each, one-cycle error pulses.

Function
REQ-016 SHALL implement states IDLE, HEADER_DONE-free flow: IDLE, DATA, CHECK, HOLD; all outputs registered.
REQ-017 IDLE: on rx_valid with rx_data[11:10]=11 SHALL latch rw_flag=1, target_mem_type=rx_data[9], target_addr=rx_data[8:0], clear byte count, go DATA.
REQ-018 IDLE: on rx_valid with rx_data[11:10]=01 SHALL latch header with rw_flag=0, leave data_out unchanged, go HOLD.
REQ-019 IDLE: header codes 00/10 SHALL be silently ignored; header registers unchanged.
REQ-020 DATA: each rx_valid SHALL store rx_data[7:0] into byte lane per MSB_FIRST and increment count; upper rx_data bits ignored.
REQ-021 DATA: on byte BYTE_COUNT accepted SHALL go CHECK if checksum compiled in, else HOLD.
REQ-022 pkt_valid SHALL rise the cycle after the final qualifying word (header for read, last byte/checksum for write) and stay high in HOLD.
REQ-023 HOLD: when pkt_valid and pkt_ready both high, SHALL drop pkt_valid next cycle and return to IDLE; data_out/header hold values until overwritten.
REQ-024 HOLD: rx_valid SHALL be dropped and pulse err_overrun; if pkt_ready is high the same cycle, the word is still dropped.
REQ-025 DATA/CHECK: idle counter SHALL clear on every rx_valid; when it reaches TIMEOUT_CYCLES SHALL pulse err_timeout, go IDLE, no pkt_valid.
REQ-026 Partial payload after timeout SHALL not be presented; next header restarts with count 0.
REQ-027 Idle counter SHALL saturate and not run in IDLE or HOLD.

Reset
REQ-028 reset SHALL force IDLE, count 0, idle counter 0, data_out 0, target_addr 0, target_mem_type 0, rw_flag 0, pkt_valid 0, all error pulses 0, on the next clk edge.
REQ-029 reset SHALL dominate all other inputs, including mid-packet and in HOLD; pending packet is discarded.

Configuration
REQ-030 Macro UART_PACKET_CHECKSUM_EN defined: write packets SHALL carry one extra word; its [7:0] compared in CHECK with XOR of all payload bytes; match -> HOLD, mismatch -> err_checksum pulse, IDLE, no pkt_valid.
REQ-031 Macro undefined: CHECK state, comparator and err_checksum logic SHALL be absent; err_checksum tied 0; DATA goes directly to HOLD.

Verification (BYTE_COUNT=4, DATA_BITS=12, TIMEOUT_CYCLES=16, MSB_FIRST=1)
REQ-032 Write: 0xE05, 0x0DE, 0x0AD, 0x0BE, 0x0EF, pkt_ready=1 -> pkt_valid one cycle, data_out=0xDEADBEEF, rw_flag=1, mem_type=1, addr=0x005.
REQ-033 Read: 0x4A3 -> pkt_valid next cycle, rw_flag=0, mem_type=0, addr=0x0A3; with pkt_ready=0 for 10 cycles pkt_valid holds 10 cycles.
REQ-034 Timeout: 0xE05, 0x011, then 16 idle cycles -> err_timeout one pulse, no pkt_valid; following full write packet completes correctly.
REQ-035 Overrun: read packet held (pkt_ready=0), send 0x0FF -> err_overrun pulse, header outputs unchanged; reset mid-DATA -> all outputs 0 next cycle.
REQ-036 With UART_PACKET_CHECKSUM_EN: payload DEADBEEF + 0x022 -> pkt_valid; same payload + 0x023 -> err_checksum pulse, no pkt_valid.
